// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch control path.
// The FSM encoding is exported as-is on the state output.
package stopwatch_pkg;

   localparam int SEC_W = 6;
   localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUNNING = 2'd1,
      PAUSED  = 2'd2,
      UNUSED  = 2'd3
   } sw_state_t;

   // Seconds successor with the 59 -> 0 wrap folded in.
   function automatic logic [SEC_W-1:0] sec_next(input logic [SEC_W-1:0] sec);
      return (sec == SEC_MAX) ? '0 : sec + 1'b1;
   endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button levels in, run/seconds/pulse status out, between the synchronisers and the datapath.
interface stopwatch_ctrl_if;

   logic                           btn_start;
   logic                           btn_stop;
   logic                           btn_clear;
   logic                           run_en;
   logic                           sec_rollover;
   logic [stopwatch_pkg::SEC_W-1:0] seconds;
   logic [1:0]                     state;
   logic                           clear_pulse;

   modport master (
      output btn_start, btn_stop, btn_clear,
      input  run_en, sec_rollover, seconds, state, clear_pulse
   );

   modport slave (
      input  btn_start, btn_stop, btn_clear,
      output run_en, sec_rollover, seconds, state, clear_pulse
   );

endinterface

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every TICK_DIV enabled cycles.
// tick is combinational so the seconds register advances on the same edge as the wrap.
module tick_prescaler #(
   parameter int TICK_DIV = 50_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic count_en,
   input  logic clr,
   output logic tick
);

   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] r_cnt;
   logic             w_at_max;

   assign w_at_max = (r_cnt == CNT_MAX);
   assign tick     = count_en & w_at_max;

   // Holding (neither clr nor count_en) is what lets a resume finish the partial second.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (count_en) begin
         r_cnt <= w_at_max ? '0 : r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: button edge detect, run/pause/idle FSM, 1 Hz prescaler and 0..59 seconds.
// Priority inside a cycle is clear > stop > start everywhere.
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int TICK_DIV = 50_000_000
) (
   input  logic             clk,
   input  logic             rst_n,
   stopwatch_ctrl_if.slave  bus
);

   logic             r_start_q;
   logic             r_stop_q;
   logic             r_clear_q;
   logic             w_rise_start;
   logic             w_rise_stop;
   logic             w_rise_clear;

   sw_state_t        r_state;
   logic             r_run_en;
   logic [SEC_W-1:0] r_seconds;
   logic             r_sec_rollover;
   logic             r_clear_pulse;

   logic             w_count_en;
   logic             w_presc_clr;
   logic             w_tick;

   // Previous samples reset high so a button held through reset release stays silent.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_start_q <= 1'b1;
         r_stop_q  <= 1'b1;
         r_clear_q <= 1'b1;
      end else begin
         r_start_q <= bus.btn_start;
         r_stop_q  <= bus.btn_stop;
         r_clear_q <= bus.btn_clear;
      end
   end

   assign w_rise_start = bus.btn_start & ~r_start_q;
   assign w_rise_stop  = bus.btn_stop  & ~r_stop_q;
   assign w_rise_clear = bus.btn_clear & ~r_clear_q;

   // A stop or clear on a would-be tick cycle suppresses that tick.
   assign w_count_en  = (r_state == RUNNING) & ~w_rise_stop & ~w_rise_clear;
   assign w_presc_clr = w_rise_clear | (r_state == IDLE);

   tick_prescaler #(
      .TICK_DIV (TICK_DIV)
   ) u_prescaler (
      .clk      (clk),
      .rst_n    (rst_n),
      .count_en (w_count_en),
      .clr      (w_presc_clr),
      .tick     (w_tick)
   );

   // run_en is loaded with the same next-state decision, so it always equals (state == RUNNING).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_run_en <= 1'b0;
      end else if (w_rise_clear) begin
         r_state  <= IDLE;
         r_run_en <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_rise_start && !w_rise_stop) begin
                  r_state  <= RUNNING;
                  r_run_en <= 1'b1;
               end
            end
            RUNNING: begin
               if (w_rise_stop) begin
                  r_state  <= PAUSED;
                  r_run_en <= 1'b0;
               end
            end
            PAUSED: begin
               if (w_rise_start && !w_rise_stop) begin
                  r_state  <= RUNNING;
                  r_run_en <= 1'b1;
               end
            end
            default: begin
               r_state  <= IDLE;
               r_run_en <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_seconds      <= '0;
         r_sec_rollover <= 1'b0;
         r_clear_pulse  <= 1'b0;
      end else if (w_rise_clear) begin
         r_seconds      <= '0;
         r_sec_rollover <= 1'b0;
         r_clear_pulse  <= 1'b1;
      end else begin
         r_clear_pulse  <= 1'b0;
         r_sec_rollover <= w_tick & (r_seconds == SEC_MAX);
         if (w_tick) begin
            r_seconds <= sec_next(r_seconds);
         end
      end
   end

   assign bus.run_en       = r_run_en;
   assign bus.state        = r_state;
   assign bus.seconds      = r_seconds;
   assign bus.sec_rollover = r_sec_rollover;
   assign bus.clear_pulse  = r_clear_pulse;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl at TICK_DIV=4: directed scenarios plus random button traffic
// against a model that tracks total counted cycles and derives seconds/rollover arithmetically.
module tb_stopwatch_ctrl;

   localparam int DIV  = 4;
   localparam int ROLL = DIV * 60;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   vectors     = 0;
   int   miscompares = 0;

   stopwatch_ctrl_if bus ();

   stopwatch_ctrl #(.TICK_DIV(DIV)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   // Reference model: state as 0/1/2, m_run = cycles counted since last clear.
   int m_state;
   int m_run;
   bit m_ps, m_pt, m_pc;
   bit e_roll, e_clr;

   logic [10:0] obs;
   assign obs = {bus.run_en, bus.sec_rollover, bus.clear_pulse, bus.state, bus.seconds};

   function automatic logic [10:0] expected();
      logic [1:0] st;
      logic [5:0] sec;
      st  = m_state[1:0];
      sec = 6'((m_run / DIV) % 60);
      return {(m_state == 1), e_roll, e_clr, st, sec};
   endfunction

   task automatic model_reset();
      m_state = 0;
      m_run   = 0;
      m_ps = 1'b1; m_pt = 1'b1; m_pc = 1'b1;
      e_roll = 1'b0; e_clr = 1'b0;
   endtask

   // Apply one cycle of button levels, advance the model, return at the following negedge.
   task automatic step(input bit s, input bit t, input bit c);
      bit rs, rt, rc;
      bus.btn_start = s;
      bus.btn_stop  = t;
      bus.btn_clear = c;
      @(posedge clk);
      rs = s & ~m_ps;
      rt = t & ~m_pt;
      rc = c & ~m_pc;
      m_ps = s; m_pt = t; m_pc = c;
      e_roll = 1'b0;
      e_clr  = 1'b0;
      if (rc) begin
         m_state = 0;
         m_run   = 0;
         e_clr   = 1'b1;
      end else begin
         if (m_state == 1 && !rt) begin
            m_run++;
            if (m_run % ROLL == 0) e_roll = 1'b1;
         end
         if (rt) begin
            if (m_state == 1) m_state = 2;
         end else if (rs && m_state != 1) begin
            m_state = 1;
         end
      end
      @(negedge clk);
      if (rs || rt || rc)
         $display("txn start=%0b stop=%0b clear=%0b -> state=%0d seconds=%0d",
                  rs, rt, rc, bus.state, bus.seconds);
   endtask

   task automatic go_idle();
      step(0, 0, 0);
      step(0, 0, 1);
      step(0, 0, 0);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus.btn_start = 1'($urandom);
         bus.btn_stop  = 1'($urandom);
         bus.btn_clear = 1'($urandom);
         @(posedge clk);
         @(negedge clk);
         vectors++;
         if (obs !== 11'd0) begin
            miscompares++;
            $display("FAIL reset_hold: outputs got %h want 000", obs);
         end
      end
      bus.btn_start = 1'b1; bus.btn_stop = 1'b0; bus.btn_clear = 1'b0;
      rst_n = 1'b1;
      model_reset();
      step(1, 0, 0);
      step(0, 0, 0);
      vectors++;
      if (bus.state !== 2'd0 || bus.run_en !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_release: state got %0d want 0, run_en got %0b want 0", bus.state, bus.run_en);
      end
   endtask

   task automatic test_start_run();
      int want_sec;
      go_idle();
      step(1, 0, 0);
      vectors++;
      if (bus.run_en !== 1'b1 || bus.state !== 2'd1) begin
         miscompares++;
         $display("FAIL start_edge: run_en=%0b state=%0d want run_en=1 state=1", bus.run_en, bus.state);
      end
      for (int k = 1; k <= ROLL + 1; k++) begin
         step(0, 0, 0);
         want_sec = (k / DIV) % 60;
         vectors++;
         if (bus.seconds !== 6'(want_sec) || bus.sec_rollover !== (k == ROLL)) begin
            miscompares++;
            $display("FAIL run_count k=%0d: seconds got %0d want %0d, rollover got %0b want %0b",
                     k, bus.seconds, want_sec, bus.sec_rollover, (k == ROLL));
         end
         if (k == ROLL) begin
            vectors++;
            if (bus.run_en !== 1'b1) begin
               miscompares++;
               $display("FAIL rollover_run_en: got %0b want 1", bus.run_en);
            end
         end
      end
   endtask

   task automatic test_pause_resume();
      go_idle();
      step(1, 0, 0);
      repeat (22) step(0, 0, 0);
      step(0, 1, 0);
      vectors++;
      if (bus.state !== 2'd2 || bus.run_en !== 1'b0 || bus.seconds !== 6'd5) begin
         miscompares++;
         $display("FAIL pause_edge: state=%0d run_en=%0b seconds=%0d want 2/0/5", bus.state, bus.run_en, bus.seconds);
      end
      repeat (20) step(0, 0, 0);
      vectors++;
      if (bus.state !== 2'd2 || bus.run_en !== 1'b0 || bus.seconds !== 6'd5) begin
         miscompares++;
         $display("FAIL pause_hold: state=%0d run_en=%0b seconds=%0d want 2/0/5", bus.state, bus.run_en, bus.seconds);
      end
      step(1, 0, 0);
      vectors++;
      if (bus.state !== 2'd1 || bus.seconds !== 6'd5) begin
         miscompares++;
         $display("FAIL resume_edge: state=%0d seconds=%0d want 1/5", bus.state, bus.seconds);
      end
      step(0, 0, 0);
      step(0, 0, 0);
      vectors++;
      if (bus.seconds !== 6'd6 || obs !== expected()) begin
         miscompares++;
         $display("FAIL resume_tick: seconds got %0d want 6 (outputs %h model %h)", bus.seconds, obs, expected());
      end
   endtask

   task automatic test_stop_on_tick();
      go_idle();
      step(1, 0, 0);
      repeat (7) step(0, 0, 0);
      step(0, 1, 0);
      vectors++;
      if (bus.seconds !== 6'd1 || bus.state !== 2'd2) begin
         miscompares++;
         $display("FAIL stop_on_tick: seconds=%0d state=%0d want 1/2", bus.seconds, bus.state);
      end
      step(0, 0, 0);
      step(1, 0, 0);
      step(0, 0, 0);
      vectors++;
      if (bus.seconds !== 6'd2) begin
         miscompares++;
         $display("FAIL stop_on_tick_resume: seconds got %0d want 2", bus.seconds);
      end
   endtask

   task automatic test_clear_on_rollover();
      go_idle();
      step(1, 0, 0);
      repeat (ROLL - 1) step(0, 0, 0);
      vectors++;
      if (bus.seconds !== 6'd59) begin
         miscompares++;
         $display("FAIL pre_clear_seconds: got %0d want 59", bus.seconds);
      end
      step(0, 0, 1);
      vectors++;
      if (obs !== {1'b0, 1'b0, 1'b1, 2'd0, 6'd0}) begin
         miscompares++;
         $display("FAIL clear_on_rollover: outputs got %h want %h", obs, {1'b0, 1'b0, 1'b1, 2'd0, 6'd0});
      end
      step(0, 0, 0);
      vectors++;
      if (obs !== 11'd0) begin
         miscompares++;
         $display("FAIL clear_after: outputs got %h want 000", obs);
      end
   endtask

   task automatic test_simultaneous();
      go_idle();
      step(1, 0, 0);
      repeat (5) step(0, 0, 0);
      step(1, 1, 0);
      vectors++;
      if (bus.state !== 2'd2 || obs !== expected()) begin
         miscompares++;
         $display("FAIL simul_running: state got %0d want 2 (outputs %h model %h)", bus.state, obs, expected());
      end
      step(0, 0, 0);
      step(1, 1, 0);
      vectors++;
      if (bus.state !== 2'd2 || bus.run_en !== 1'b0) begin
         miscompares++;
         $display("FAIL simul_paused: state=%0d run_en=%0b want 2/0", bus.state, bus.run_en);
      end
   endtask

   task automatic test_held_reset();
      bus.btn_start = 1'b1; bus.btn_stop = 1'b0; bus.btn_clear = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         step(1, 0, 0);
         vectors++;
         if (bus.state !== 2'd0) begin
            miscompares++;
            $display("FAIL held_start cycle %0d: state got %0d want 0", i, bus.state);
         end
      end
      step(0, 0, 0);
      step(1, 0, 0);
      vectors++;
      if (bus.state !== 2'd1 || bus.run_en !== 1'b1) begin
         miscompares++;
         $display("FAIL held_restart: state=%0d run_en=%0b want 1/1", bus.state, bus.run_en);
      end
   endtask

   task automatic test_async_reset();
      go_idle();
      step(1, 0, 0);
      repeat (30 + $urandom_range(0, 200)) step(0, 0, 0);
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if (obs !== 11'd0) begin
         miscompares++;
         $display("FAIL async_reset_immediate: outputs got %h want 000", obs);
      end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         vectors++;
         if (obs !== 11'd0) begin
            miscompares++;
            $display("FAIL async_reset_hold: outputs got %h want 000", obs);
         end
      end
      rst_n = 1'b1;
      model_reset();
      step(0, 0, 0);
      vectors++;
      if (obs !== 11'd0 || obs !== expected()) begin
         miscompares++;
         $display("FAIL async_reset_release: outputs got %h want 000", obs);
      end
   endtask

   task automatic test_random();
      bit s, t, c;
      go_idle();
      s = 1'b0; t = 1'b0; c = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 7) == 0)   s = ~s;
         if ($urandom_range(0, 49) == 0)  t = ~t;
         if ($urandom_range(0, 299) == 0) c = ~c;
         step(s, t, c);
         vectors++;
         if (obs !== expected()) begin
            miscompares++;
            $display("FAIL random cycle %0d: outputs got %h want %h", i, obs, expected());
         end
      end
   endtask

   initial begin
      bus.btn_start = 1'b0;
      bus.btn_stop  = 1'b0;
      bus.btn_clear = 1'b0;
      model_reset();
      @(negedge clk);
      test_reset();
      test_start_run();
      test_pause_resume();
      test_stop_on_tick();
      test_clear_on_rollover();
      test_simultaneous();
      test_held_reset();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Control block for the stopwatch. It turns the three button levels (start, stop, clear) into a run/pause/idle state machine and divides the system clock into a 1 Hz tick. It keeps the 0–59 seconds count and drives the enable/rollover pair consumed by the minutes counter. It sits between the button synchronisers and the counting datapath.

## Interface
Parameters:
- TICK_DIV, 50_000_000: clk cycles per seconds increment; legal range ≥ 2.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- btn_start  in  1  synchronised, debounced level; its rising edge is the start/resume command.
- btn_stop  in  1  synchronised, debounced level; its rising edge is the pause command.
- btn_clear  in  1  synchronised, debounced level; its rising edge is the clear command.
- run_en  out  1  high exactly while state is RUNNING; drives the minutes counter enable.
- sec_rollover  out  1  one-cycle pulse in the cycle after seconds wraps 59→0.
- seconds  out  6  current seconds, 0..59.
- state  out  2  current FSM state encoding.
- clear_pulse  out  1  one-cycle pulse after a clear command; top level uses it to clear the minutes counter.

## Operation
- Edge detect:
  - rise_x = btn_x & ~btn_x_q, where btn_x_q is the previous-cycle sample.
  - btn_x_q resets to 1, so a button held through reset release never fires a command.
- Command priority within one cycle: clear > stop > start.
- FSM states: IDLE=0, RUNNING=1, PAUSED=2; encoding 3 is unreachable and recovers to IDLE.
  - IDLE: rise_start → RUNNING; rise_stop ignored.
  - RUNNING: rise_stop → PAUSED; rise_start ignored.
  - PAUSED: rise_start → RUNNING (resume); rise_stop ignored.
  - Any state: rise_clear → IDLE.
- Prescaler, width clog2(TICK_DIV):
  - Counts only when state==RUNNING and no stop or clear command is active this cycle.
  - On reaching TICK_DIV-1 it wraps to 0 and issues an internal tick.
  - It holds its value in PAUSED, so a resume continues the partial second.
  - It is zeroed in IDLE and on clear.
- Seconds:
  - On a tick, seconds increments.
  - At 59 a tick sets seconds to 0 and registers sec_rollover=1 for exactly one cycle.
- Clear: seconds=0, prescaler=0, sec_rollover=0; clear_pulse registered high for one cycle.
- run_en and state are decoded from the state register; no extra pipeline stage.

## Timing
- Reset values: state=IDLE, run_en=0, seconds=0, sec_rollover=0, clear_pulse=0, prescaler=0, all btn_x_q=1.
- Command latency: a command is acted on at the first rising edge where btn_x=1 and btn_x_q=0. state and run_en reflect the change right after that edge.
- First tick after start from IDLE: seconds reads 1 exactly TICK_DIV cycles after the edge that entered RUNNING.
- Rollover timing:
  - seconds 59→0 and sec_rollover=1 appear after the same edge.
  - run_en is still 1 in that cycle, so the minutes counter increments at the following edge.
- Stop on a tick cycle: the stop wins. The tick is suppressed and seconds and prescaler hold.
- Clear on a tick or rollover cycle: the clear wins. No sec_rollover is emitted.
- Reset asserted mid-count: all registers return to reset values asynchronously. No pulse outputs may appear during or after reset.

## Structure
- Package stopwatch_pkg holds:
  - state typedef and encodings IDLE/RUNNING/PAUSED;
  - SEC_MAX=59;
  - the seconds width constant (6).
- Sub-module tick_prescaler:
  - parameter TICK_DIV; inputs clk, rst_n, count_en, clr; output tick.
  - Instantiated once.
- FSM, edge detect and seconds logic live in stopwatch_ctrl.

## Test plan
All scenarios use TICK_DIV=4.
- Reset: hold rst_n=0 with buttons toggling → all outputs 0 and state=IDLE. Release → still IDLE.
- Start and run: rise btn_start → run_en=1 next cycle. seconds=1 after 4 cycles. After 240 cycles seconds=0 with sec_rollover high for exactly one cycle.
- Pause and resume:
  - Stop when seconds=5 with prescaler at 2, then wait 20 cycles → seconds stays 5, run_en=0, state=PAUSED.
  - Start → seconds=6 two cycles later.
- Clear while running at seconds=59 on the tick cycle → state=IDLE, seconds=0, clear_pulse one cycle, no sec_rollover.
- Simultaneous stop and start rising edges:
  - in RUNNING → PAUSED;
  - in PAUSED → stays PAUSED.
- Button held high across reset release → no state change until it falls and rises again.
